// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write arbiter.
//   REG_PC / REG_LR : architectural register numbers
//   *_DEF           : default address/data widths
//   REQ_*           : requester slot assignment on the arbiter
//   wr_state_t      : write-issue FSM state
package regfile_pkg;
  localparam logic [3:0] REG_PC = 4'd15;
  localparam logic [3:0] REG_LR = 4'd14;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 32;

  localparam int REQ_ALU  = 0;
  localparam int REQ_MEM  = 1;
  localparam int REQ_LINK = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,  // no write this cycle
    ST_ISSUE = 1'b1   // WE asserted this cycle
  } wr_state_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the requesters and the register-file write port.
//   master : requester side (drives VALID/ADDR/DATA/HOLD, sees READY and port state)
//   slave  : arbiter side
interface regfile_write_arbiter_if #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic [NREQ-1:0]        REQ_VALID;
  logic [NREQ*ADDR_W-1:0] REQ_ADDR;
  logic [NREQ*DATA_W-1:0] REQ_DATA;
  logic [NREQ-1:0]        REQ_READY;
  logic                   HOLD;
  logic                   WE;
  logic [ADDR_W-1:0]      WA;
  logic [DATA_W-1:0]      WD;
  logic                   ERR_PC_WR;
  logic [CNT_W-1:0]       CONFLICT_CNT;

  modport master (
    output REQ_VALID, REQ_ADDR, REQ_DATA, HOLD,
    input  REQ_READY, WE, WA, WD, ERR_PC_WR, CONFLICT_CNT
  );

  modport slave (
    input  REQ_VALID, REQ_ADDR, REQ_DATA, HOLD,
    output REQ_READY, WE, WA, WD, ERR_PC_WR, CONFLICT_CNT
  );
endinterface

// File: rtl/regfile_rr_pick.sv
// Combinational round-robin pick.
//   i_valid : request vector
//   i_ptr   : highest-priority index this cycle
//   o_grant : one-hot grant (0 when nothing valid)
//   o_idx   : binary index of the grant
//   o_any   : at least one requester valid
module regfile_rr_pick #(
  parameter int NREQ  = 3,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  i_valid,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_grant,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_any
);
  localparam logic [PTR_W:0] NREQ_W = (PTR_W+1)'(NREQ);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [PTR_W-1:0]  w_sel;
  logic [PTR_W:0]    w_sum;
  logic [PTR_W:0]    w_wrap;

  // Rotate so that i_ptr lands at bit 0; the doubled vector makes it a plain slice.
  assign w_dbl = {i_valid, i_valid};
  assign w_rot = w_dbl[i_ptr +: NREQ];

  // Lowest set bit of the rotated vector wins.
  always_comb begin
    w_sel = '0;
    o_any = 1'b0;
    for (int j = NREQ-1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_sel = PTR_W'(j);
        o_any = 1'b1;
      end
    end
  end

  // Rotate back: idx = (ptr + sel) mod NREQ.
  assign w_sum  = {1'b0, i_ptr} + {1'b0, w_sel};
  assign w_wrap = w_sum - NREQ_W;
  assign o_idx  = (w_sum >= NREQ_W) ? w_wrap[PTR_W-1:0] : w_sum[PTR_W-1:0];

  assign o_grant = o_any ? (NREQ'(1) << o_idx) : '0;
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port.
//   CLK   : system clock, posedge state updates
//   RESET : asynchronous active-high reset
//   bus   : requester handshakes in, registered WE/WA/WD, PC-write error
//           pulse and saturating conflict counter out
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input logic                     CLK,
  input logic                     RESET,
  regfile_write_arbiter_if.slave  bus
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  wr_state_t         r_state, w_state_nxt;
  logic [PTR_W-1:0]  r_ptr;
  logic [ADDR_W-1:0] r_wa;
  logic [DATA_W-1:0] r_wd;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;

  logic [NREQ-1:0]   w_onehot;
  logic [PTR_W-1:0]  w_idx;
  logic              w_any;
  logic              w_grant;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_is_pc;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic [3:0]        w_pop;
  logic              w_conflict;

  regfile_rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
    .i_valid (bus.REQ_VALID),
    .i_ptr   (r_ptr),
    .o_grant (w_onehot),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // READY is forced low during reset so an in-flight grant is not consumed.
  assign w_grant       = w_any & ~bus.HOLD & ~RESET;
  assign bus.REQ_READY = w_grant ? w_onehot : '0;

  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_onehot[i]) begin
        w_addr = bus.REQ_ADDR[i*ADDR_W +: ADDR_W];
        w_data = bus.REQ_DATA[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_is_pc   = (w_addr == ADDR_W'(REG_PC));
  assign w_ptr_nxt = (w_idx == PTR_W'(NREQ-1)) ? '0 : w_idx + PTR_W'(1);

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NREQ; i++) w_pop = w_pop + 4'(bus.REQ_VALID[i]);
  end
  assign w_conflict = (w_pop > 4'd1) & ~bus.HOLD;

  // FSM: the state itself is WE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = ST_IDLE;
    if (w_grant && !w_is_pc) w_state_nxt = ST_ISSUE;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ptr <= '0;
      r_wa  <= '0;
      r_wd  <= '0;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_err <= w_grant & w_is_pc;
      if (w_grant) begin
        // Address/data latch even for a dropped PC write.
        r_wa  <= w_addr;
        r_wd  <= w_data;
        r_ptr <= w_ptr_nxt;
      end
      if (w_conflict && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.WE           = (r_state == ST_ISSUE);
  assign bus.WA           = r_wa;
  assign bus.WD           = r_wd;
  assign bus.ERR_PC_WR    = r_err;
  assign bus.CONFLICT_CNT = r_cnt;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
  localparam int NREQ = 3, AW = 4, DW = 32, CW = 4;

  logic CLK = 1'b0;
  logic RESET;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  regfile_write_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();

  regfile_write_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after posedge; registered outputs are checked then.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [31:0] d);
    bus.REQ_ADDR[i*AW +: AW] = a;
    bus.REQ_DATA[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    bus.REQ_VALID = '0;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    #1;
  endtask

  logic [31:0] dat [3];
  logic [3:0]  adr [3];

  initial begin
    adr[0] = 4'd1; dat[0] = 32'h1111_1111;
    adr[1] = 4'd2; dat[1] = 32'h2222_2222;
    adr[2] = 4'd5; dat[2] = 32'h3333_3333;
    for (int i = 0; i < NREQ; i++) set_req(i, adr[i], dat[i]);
    bus.HOLD      = 1'b0;
    bus.REQ_VALID = 3'b111;
    RESET         = 1'b1;
    #1;

    // 1: reset
    chk("rst_ready", 32'(bus.REQ_READY), 32'h0);
    chk("rst_we",    32'(bus.WE), 32'h0);
    chk("rst_wa",    32'(bus.WA), 32'h0);
    chk("rst_wd",    bus.WD, 32'h0);
    chk("rst_err",   32'(bus.ERR_PC_WR), 32'h0);
    chk("rst_cnt",   32'(bus.CONFLICT_CNT), 32'h0);
    tick();
    RESET = 1'b0;
    #1;
    chk("rel_ready0", 32'(bus.REQ_READY), 32'b001);
    tick();
    chk("rel_we", 32'(bus.WE), 32'h1);
    chk("rel_wa", 32'(bus.WA), 32'(adr[0]));
    chk("rel_cnt", 32'(bus.CONFLICT_CNT), 32'h1);
    RESET = 1'b1;  // mid-grant: req1 currently READY
    #1;
    chk("midrst_ready", 32'(bus.REQ_READY), 32'h0);
    chk("midrst_we",    32'(bus.WE), 32'h0);
    chk("midrst_cnt",   32'(bus.CONFLICT_CNT), 32'h0);
    tick();
    chk("midrst_ready2", 32'(bus.REQ_READY), 32'h0);
    RESET = 1'b0;
    #1;
    chk("post_rst_grant", 32'(bus.REQ_READY), 32'b001);
    bus.REQ_VALID = '0;
    tick();
    chk("post_rst_idle_we", 32'(bus.WE), 32'h0);

    // 2: single requester (rr_ptr still 0)
    set_req(1, 4'd3, 32'hDEAD_BEEF);
    bus.REQ_VALID = 3'b010;
    #1;
    chk("single_ready", 32'(bus.REQ_READY), 32'b010);
    tick();
    bus.REQ_VALID = '0;
    chk("single_we", 32'(bus.WE), 32'h1);
    chk("single_wa", 32'(bus.WA), 32'h3);
    chk("single_wd", bus.WD, 32'hDEAD_BEEF);
    chk("single_err", 32'(bus.ERR_PC_WR), 32'h0);
    tick();
    chk("single_we_off", 32'(bus.WE), 32'h0);
    chk("single_wa_keep", 32'(bus.WA), 32'h3);
    chk("single_wd_keep", bus.WD, 32'hDEAD_BEEF);
    set_req(1, adr[1], dat[1]);

    // 3: round-robin over all three
    do_reset();
    bus.REQ_VALID = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("rr_ready%0d", k), 32'(bus.REQ_READY), 32'(1 << (k % 3)));
      tick();
      chk($sformatf("rr_we%0d", k), 32'(bus.WE), 32'h1);
      chk($sformatf("rr_wa%0d", k), 32'(bus.WA), 32'(adr[k % 3]));
      chk($sformatf("rr_wd%0d", k), bus.WD, dat[k % 3]);
    end
    bus.REQ_VALID = '0;
    chk("rr_cnt", 32'(bus.CONFLICT_CNT), 32'd6);
    tick();
    chk("rr_we_off", 32'(bus.WE), 32'h0);

    // 4: PC write, rr_ptr back at 0
    set_req(0, 4'd15, 32'hCAFE_0000);
    bus.REQ_VALID = 3'b001;
    #1;
    chk("pc_ready", 32'(bus.REQ_READY), 32'b001);
    tick();
    bus.REQ_VALID = '0;
    chk("pc_we", 32'(bus.WE), 32'h0);
    chk("pc_err", 32'(bus.ERR_PC_WR), 32'h1);
    tick();
    chk("pc_err_off", 32'(bus.ERR_PC_WR), 32'h0);
    chk("pc_cnt", 32'(bus.CONFLICT_CNT), 32'd6);
    set_req(0, adr[0], dat[0]);

    // 5: HOLD with rr_ptr = 1
    bus.HOLD      = 1'b1;
    bus.REQ_VALID = 3'b011;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("hold_ready%0d", k), 32'(bus.REQ_READY), 32'h0);
      tick();
      chk($sformatf("hold_we%0d", k), 32'(bus.WE), 32'h0);
      chk($sformatf("hold_cnt%0d", k), 32'(bus.CONFLICT_CNT), 32'd6);
    end
    bus.HOLD = 1'b0;
    #1;
    chk("hold_resume", 32'(bus.REQ_READY), 32'b010);
    tick();
    bus.REQ_VALID = '0;
    chk("hold_resume_wa", 32'(bus.WA), 32'(adr[1]));
    chk("hold_resume_cnt", 32'(bus.CONFLICT_CNT), 32'd7);

    // same destination from two requesters: last granted wins
    do_reset();
    set_req(0, 4'd6, 32'hAAAA_0000);
    set_req(1, 4'd6, 32'hBBBB_0000);
    bus.REQ_VALID = 3'b011;
    tick();
    chk("same_wd0", bus.WD, 32'hAAAA_0000);
    bus.REQ_VALID = 3'b010;
    tick();
    bus.REQ_VALID = '0;
    chk("same_wa", 32'(bus.WA), 32'h6);
    chk("same_wd1", bus.WD, 32'hBBBB_0000);
    set_req(0, adr[0], dat[0]);
    set_req(1, adr[1], dat[1]);

    // 6: saturation with a 4-bit counter
    do_reset();
    bus.REQ_VALID = 3'b111;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 13) chk("sat_cnt14", 32'(bus.CONFLICT_CNT), 32'hE);
    end
    chk("sat_cnt20", 32'(bus.CONFLICT_CNT), 32'hF);
    bus.REQ_VALID = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
